// File: rtl/lc3_control_fsm.sv
// LC-3 microsequencer: Moore FSM driving datapath loads, bus gates, muxes.
// Ports: clk/reset, ir+nzp+memReady in; load/gate/select/memory/halted out.
module lc3_control_fsm #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        memReady,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        ldIR,
  output logic        ldPC,
  output logic        ldReg,
  output logic        ldCC,
  output logic        gatePC,
  output logic        gateMDR,
  output logic        gateALU,
  output logic        gateMARMUX,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        selMAR,
  output logic        selMDR,
  output logic        sr1Mux,
  output logic        drMux,
  output logic [1:0]  aluK,
  output logic        memEn,
  output logic        memWE,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_INIT, S_F0, S_F1, S_F2, S_DEC,
    S_ALU, S_BR, S_JMP, S_JSR0, S_JSR1,
    S_ADR, S_RDI, S_IND, S_RD, S_WB,
    S_ST0, S_ST1, S_LEA, S_HALT
  } state_e;

  localparam logic [31:0] TO_LIM =
    32'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  op;
  logic        br_taken;
  logic        mem_st;
  logic        timed_out;
  logic        unused_ir;

  assign op        = ir[15:12];
  assign br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign unused_ir = ^ir[8:0];
  assign mem_st    = (state_q == S_F1) || (state_q == S_RDI) ||
                     (state_q == S_RD) || (state_q == S_ST1);
  // cnt_q is the number of cycles already spent in this memory state
  assign timed_out = (MEM_TIMEOUT > 0) && !memReady &&
                     (cnt_q >= TO_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // counter restarts on every state change, so each memory state
  // gets its own full timeout window
  always_comb begin
    cnt_d = '0;
    if (mem_st && (state_d == state_q))
      cnt_d = cnt_q + 32'd1;
  end

  always_comb begin
    state_d    = state_q;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    ldIR       = 1'b0;
    ldPC       = 1'b0;
    ldReg      = 1'b0;
    ldCC       = 1'b0;
    gatePC     = 1'b0;
    gateMDR    = 1'b0;
    gateALU    = 1'b0;
    gateMARMUX = 1'b0;
    selPC      = 2'b00;
    selEAB1    = 1'b0;
    selEAB2    = 2'b00;
    selMAR     = 1'b0;
    selMDR     = 1'b0;
    sr1Mux     = 1'b0;
    drMux      = 1'b0;
    aluK       = 2'b00;
    memEn      = 1'b0;
    memWE      = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_F0;
      S_F0: begin
        gatePC  = 1'b1;
        ldMAR   = 1'b1;
        ldPC    = 1'b1;
        state_d = S_F1;
      end
      S_F1, S_RDI, S_RD: begin
        memEn = 1'b1;
        if (memReady) begin
          ldMDR = 1'b1;
          unique case (state_q)
            S_F1:    state_d = S_F2;
            S_RDI:   state_d = S_IND;
            default: state_d = S_WB;
          endcase
        end else if (timed_out) begin
          state_d = S_HALT;
        end
      end
      S_F2: begin
        gateMDR = 1'b1;
        ldIR    = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        unique case (op)
          4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
          4'b0000: state_d = br_taken ? S_BR : S_F0;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR0;
          4'b0010, 4'b0110, 4'b1010,
          4'b0011, 4'b0111, 4'b1011: state_d = S_ADR;
          4'b1110: state_d = S_LEA;
          default: state_d = S_HALT;
        endcase
      end
      S_ALU: begin
        gateALU = 1'b1;
        ldReg   = 1'b1;
        ldCC    = 1'b1;
        unique case (op)
          4'b0101: aluK = 2'b01;
          4'b1001: aluK = 2'b10;
          default: aluK = 2'b00;
        endcase
        state_d = S_F0;
      end
      S_BR: begin
        ldPC    = 1'b1;
        selPC   = 2'b01;
        selEAB2 = 2'b10;
        state_d = S_F0;
      end
      S_JMP: begin
        ldPC    = 1'b1;
        selPC   = 2'b01;
        selEAB1 = 1'b1;
        state_d = S_F0;
      end
      S_JSR0: begin
        gatePC  = 1'b1;
        ldReg   = 1'b1;
        drMux   = 1'b1;
        state_d = S_JSR1;
      end
      S_JSR1: begin
        ldPC    = 1'b1;
        selPC   = 2'b01;
        // ir[11]: PC-relative JSR, else register-based JSRR
        selEAB1 = ~ir[11];
        selEAB2 = ir[11] ? 2'b11 : 2'b00;
        state_d = S_F0;
      end
      S_ADR: begin
        gateMARMUX = 1'b1;
        selMAR     = 1'b1;
        ldMAR      = 1'b1;
        // LDR/STR are base+off6, the rest PC+off9
        if (op[3:1] == 3'b011) begin
          selEAB1 = 1'b1;
          selEAB2 = 2'b01;
        end else begin
          selEAB2 = 2'b10;
        end
        unique case (op)
          4'b0010, 4'b0110: state_d = S_RD;
          4'b1010, 4'b1011: state_d = S_RDI;
          default:          state_d = S_ST0;
        endcase
      end
      S_IND: begin
        gateMDR = 1'b1;
        ldMAR   = 1'b1;
        state_d = op[0] ? S_ST0 : S_RD;
      end
      S_WB: begin
        gateMDR = 1'b1;
        ldReg   = 1'b1;
        ldCC    = 1'b1;
        state_d = S_F0;
      end
      S_ST0: begin
        sr1Mux  = 1'b1;
        aluK    = 2'b11;
        gateALU = 1'b1;
        selMDR  = 1'b1;
        ldMDR   = 1'b1;
        state_d = S_ST1;
      end
      S_ST1: begin
        memEn = 1'b1;
        memWE = 1'b1;
        if (memReady)
          state_d = S_F0;
        else if (timed_out)
          state_d = S_HALT;
      end
      S_LEA: begin
        gateMARMUX = 1'b1;
        selMAR     = 1'b1;
        selEAB2    = 2'b10;
        ldReg      = 1'b1;
        state_d    = S_F0;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: instruction-level model of expected control
// words, randomized instructions and memory stalls, two timeout settings.
module tb_lc3_control_fsm;

  localparam bit [23:0] LDMAR  = 24'h1 << 23;
  localparam bit [23:0] LDMDR  = 24'h1 << 22;
  localparam bit [23:0] LDIR   = 24'h1 << 21;
  localparam bit [23:0] LDPC   = 24'h1 << 20;
  localparam bit [23:0] LDREG  = 24'h1 << 19;
  localparam bit [23:0] LDCC   = 24'h1 << 18;
  localparam bit [23:0] GPC    = 24'h1 << 17;
  localparam bit [23:0] GMDR   = 24'h1 << 16;
  localparam bit [23:0] GALU   = 24'h1 << 15;
  localparam bit [23:0] GMARMX = 24'h1 << 14;
  localparam bit [23:0] PCEAB  = 24'h1 << 12;
  localparam bit [23:0] EAB1   = 24'h1 << 11;
  localparam bit [23:0] OFF6   = 24'h1 << 9;
  localparam bit [23:0] OFF9   = 24'h2 << 9;
  localparam bit [23:0] OFF11  = 24'h3 << 9;
  localparam bit [23:0] SELMAR = 24'h1 << 8;
  localparam bit [23:0] SELMDR = 24'h1 << 7;
  localparam bit [23:0] SR1MX  = 24'h1 << 6;
  localparam bit [23:0] DRMX   = 24'h1 << 5;
  localparam bit [23:0] MEMEN  = 24'h1 << 2;
  localparam bit [23:0] MEMWE  = 24'h1 << 1;
  localparam bit [23:0] HALTED = 24'h1;

  localparam bit [23:0] W_F0 = GPC | LDMAR | LDPC;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        n, z, p;
  logic        memReady;

  int n_assert;
  int n_fail;

  bit [23:0] eq[$];
  bit        rq[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic ldMAR, ldMDR, ldIR, ldPC, ldReg, ldCC;
    logic gatePC, gateMDR, gateALU, gateMARMUX;
    logic [1:0] selPC, selEAB2, aluK;
    logic selEAB1, selMAR, selMDR, sr1Mux, drMux;
    logic memEn, memWE, halted;
    logic [23:0] obs;
    lc3_control_fsm #(.MEM_TIMEOUT(g * 4)) u_dut (
      .clk(clk), .reset(reset), .ir(ir),
      .n(n), .z(z), .p(p), .memReady(memReady),
      .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR),
      .ldPC(ldPC), .ldReg(ldReg), .ldCC(ldCC),
      .gatePC(gatePC), .gateMDR(gateMDR),
      .gateALU(gateALU), .gateMARMUX(gateMARMUX),
      .selPC(selPC), .selEAB1(selEAB1), .selEAB2(selEAB2),
      .selMAR(selMAR), .selMDR(selMDR),
      .sr1Mux(sr1Mux), .drMux(drMux), .aluK(aluK),
      .memEn(memEn), .memWE(memWE), .halted(halted)
    );
    assign obs = {ldMAR, ldMDR, ldIR, ldPC, ldReg, ldCC,
                  gatePC, gateMDR, gateALU, gateMARMUX,
                  selPC, selEAB1, selEAB2, selMAR, selMDR,
                  sr1Mux, drMux, aluK, memEn, memWE, halted};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk2(input bit [23:0] e0, input bit [23:0] e1,
                      input string tag);
    n_assert++;
    assert (g_dut[0].obs === e0) else begin
      n_fail++;
      $error("FAIL %s dut0 observed=%h expected=%h",
             tag, g_dut[0].obs, e0);
    end
    n_assert++;
    assert (g_dut[1].obs === e1) else begin
      n_fail++;
      $error("FAIL %s dut1 observed=%h expected=%h",
             tag, g_dut[1].obs, e1);
    end
  endtask

  task automatic plain(input bit [23:0] w);
    eq.push_back(w);
    rq.push_back(1'($urandom));
  endtask

  task automatic mem(input bit [23:0] w_wait, input bit [23:0] w_rdy,
                     input int waits);
    for (int i = 0; i < waits; i++) begin
      eq.push_back(w_wait);
      rq.push_back(1'b0);
    end
    eq.push_back(w_rdy);
    rq.push_back(1'b1);
  endtask

  // Expected control words of one instruction, cycle by cycle.
  task automatic model(input bit [15:0] i, input bit [2:0] cc,
                       input int w0, input int w1, input int w2);
    bit [3:0]  op;
    bit [23:0] adr;
    op  = i[15:12];
    adr = GMARMX | SELMAR | LDMAR |
          ((op == 4'h6 || op == 4'h7) ? (EAB1 | OFF6) : OFF9);
    plain(W_F0);
    mem(MEMEN, MEMEN | LDMDR, w0);
    plain(GMDR | LDIR);
    plain(24'h0);
    case (op)
      4'h1: plain(GALU | LDREG | LDCC);
      4'h5: plain(GALU | LDREG | LDCC | (24'h1 << 3));
      4'h9: plain(GALU | LDREG | LDCC | (24'h2 << 3));
      4'h0: if ((i[11:9] & cc) != 3'b000) plain(LDPC | PCEAB | OFF9);
      4'hC: plain(LDPC | PCEAB | EAB1);
      4'h4: begin
        plain(GPC | LDREG | DRMX);
        plain(LDPC | PCEAB | (i[11] ? OFF11 : EAB1));
      end
      4'h2, 4'h6: begin
        plain(adr);
        mem(MEMEN, MEMEN | LDMDR, w1);
        plain(GMDR | LDREG | LDCC);
      end
      4'hA: begin
        plain(adr);
        mem(MEMEN, MEMEN | LDMDR, w1);
        plain(GMDR | LDMAR);
        mem(MEMEN, MEMEN | LDMDR, w2);
        plain(GMDR | LDREG | LDCC);
      end
      4'h3, 4'h7: begin
        plain(adr);
        plain(SR1MX | (24'h3 << 3) | GALU | SELMDR | LDMDR);
        mem(MEMEN | MEMWE, MEMEN | MEMWE, w1);
      end
      4'hB: begin
        plain(adr);
        mem(MEMEN, MEMEN | LDMDR, w1);
        plain(GMDR | LDMAR);
        plain(SR1MX | (24'h3 << 3) | GALU | SELMDR | LDMDR);
        mem(MEMEN | MEMWE, MEMEN | MEMWE, w2);
      end
      4'hE: plain(GMARMX | SELMAR | OFF9 | LDREG);
      default: for (int k = 0; k < 20; k++) plain(HALTED);
    endcase
  endtask

  task automatic exec(input bit [15:0] i, input bit [2:0] cc,
                      input int w0, input int w1, input int w2,
                      input int limit);
    int len;
    eq.delete();
    rq.delete();
    model(i, cc, w0, w1, w2);
    len = eq.size();
    for (int k = 0; k < len && k < limit; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ir = i;
        {n, z, p} = cc;
      end
      memReady = rq[k];
      #1;
      chk2(eq[k], eq[k], $sformatf("ir=%h step=%0d", i, k));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk2(24'h0, 24'h0, "reset_init");
  endtask

  initial begin
    bit [3:0] ops [13];
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ir       = 16'h0;
    {n, z, p} = 3'b000;
    memReady = 1'b1;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
            4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
    repeat (2) @(negedge clk);
    do_reset();

    exec(16'h1042, 3'b000, 0, 0, 0, 99);
    exec(16'h0A05, 3'b010, 0, 0, 0, 99);
    exec(16'h0A05, 3'b100, 0, 0, 0, 99);
    exec(16'hA203, 3'b000, 3, 3, 3, 99);
    exec(16'h4801, 3'b000, 0, 0, 0, 99);
    exec(16'h4080, 3'b000, 1, 0, 0, 99);
    exec(16'hB401, 3'b000, 2, 3, 3, 99);
    exec(16'hE1FF, 3'b000, 0, 0, 0, 99);

    for (int t = 0; t < 40; t++) begin
      bit [15:0] ri;
      ri = {ops[$urandom_range(12)], 12'($urandom)};
      exec(ri, 3'($urandom), $urandom_range(3),
           $urandom_range(3), $urandom_range(3), 99);
    end

    exec(16'hF025, 3'b000, 0, 0, 0, 99);
    do_reset();

    // memory never answers: dut0 waits, dut1 gives up after 4 cycles
    @(negedge clk);
    ir = 16'h1042;
    memReady = 1'b0;
    #1;
    chk2(W_F0, W_F0, "to_f0");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk2(MEMEN, MEMEN, $sformatf("to_f1_%0d", k));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk2(MEMEN, HALTED, $sformatf("to_halt_%0d", k));
    end
    do_reset();

    exec(16'h3200, 3'b000, 0, 5, 0, 8);
    do_reset();
    exec(16'h5123, 3'b000, 0, 0, 0, 99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_control_fsm.md
Name: lc3_control_fsm

Overview:
- Microsequencer for the LC-3 datapath: Moore FSM that fetches, decodes and executes one instruction at a time.
- Drives the load enables, bus gates and mux selects of the PC, MAR/MDR, IR, register file, ALU and EAB adder.
- Handshakes with memory through memEn/memWE/memReady.
- Sits beside the datapath top level; the datapath sees only these control lines.

Parameters:
MEM_TIMEOUT, 0, max cycles to wait for memReady in any memory state; 0 = wait forever.

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high
ir  input  16  current IR contents
n, z, p  input  1 each  condition codes from the CC register
memReady  input  1  memory completes the current read/write this cycle
ldMAR, ldMDR, ldIR, ldPC, ldReg, ldCC  output  1 each  register load enables
gatePC, gateMDR, gateALU, gateMARMUX  output  1 each  bus drivers; at most one high per cycle
selPC  output  2  PC source: 00 PC+1, 01 eabOut, 10 Bus
selEAB1  output  1  EAB base: 0 PC, 1 SR1
selEAB2  output  2  EAB offset: 00 zero, 01 SEXT off6, 10 SEXT off9, 11 SEXT off11
selMAR  output  1  MARMUX: 0 ZEXT ir[7:0], 1 EAB
selMDR  output  1  MDR source: 0 memory, 1 Bus
sr1Mux  output  1  SR1 address: 0 ir[8:6], 1 ir[11:9]
drMux  output  1  DR address: 0 ir[11:9], 1 R7
aluK  output  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
memEn, memWE  output  1 each  memory request / write strobe
halted  output  1  FSM parked in HALT

Behaviour:
- Outputs decode from the registered state only (Moore). Every signal not listed for a state is 0.
- Reset has priority over everything, including mid-instruction and HALT:
  - next state INIT.
  - INIT drives all outputs 0 for one cycle, then goes to F0.
- Fetch sequence:
  - F0: gatePC, ldMAR, ldPC, selPC=00. Next F1.
  - F1: memEn. When memReady=1: ldMDR with selMDR=0, next F2. Otherwise stay in F1 with ldMDR=0.
  - F2: gateMDR, ldIR. Next DEC.
- DEC: no outputs. Branch on ir[15:12]:
  - 0001/0101/1001 → ALU
  - 0000 → BR if (ir[11]&n)|(ir[10]&z)|(ir[9]&p), else F0
  - 1100 → JMP
  - 0100 → JSR0
  - 0010/0110/1010/0011/0111/1011 → ADR
  - 1110 → LEA
  - 1111/1000/1101 → HALT
- Execute states:
  - ALU: gateALU, ldReg, ldCC; aluK = 00/01/10 for ADD/AND/NOT. Next F0.
  - BR: ldPC, selPC=01, selEAB1=0, selEAB2=10. Next F0.
  - JMP: ldPC, selPC=01, selEAB1=1, selEAB2=00. Next F0.
  - JSR0: gatePC, ldReg, drMux=1. Next JSR1.
  - JSR1: ldPC, selPC=01. If ir[11]=1, selEAB1=0 and selEAB2=11; otherwise selEAB1=1 and selEAB2=00. Next F0.
  - ADR: gateMARMUX, selMAR=1, ldMAR. LD/LDI/ST/STI use selEAB1=0, selEAB2=10; LDR/STR use selEAB1=1, selEAB2=01. Next: LD/LDR → RD, LDI/STI → RDI, ST/STR → ST0.
  - RDI: memEn, ldMDR on ready (same rules as F1). Next IND.
  - IND: gateMDR, ldMAR. Next RD for LDI, ST0 for STI.
  - RD: memEn, ldMDR on ready. Next WB.
  - WB: gateMDR, ldReg, ldCC. Next F0.
  - ST0: sr1Mux=1, aluK=11, gateALU, selMDR=1, ldMDR. Next ST1.
  - ST1: memEn, memWE. Stay until memReady, then F0.
  - LEA: gateMARMUX, selMAR=1, selEAB1=0, selEAB2=10, ldReg; ldCC=0. Next F0.
  - HALT: halted=1, all other outputs 0. Remains until reset.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entry to each memory state (F1, RDI, RD, ST1).
  - If memReady is still low after MEM_TIMEOUT cycles in that state, next state is HALT.
- memReady is ignored outside memory states.
- Latency with memReady tied high:
  - ALU/LEA/JMP: 5 cycles.
  - BR taken: 5 cycles; not taken: 4 cycles.
  - JSR: 6 cycles.
  - LD/LDR: 7 cycles.
  - ST/STR: 7 cycles.
  - LDI: 9 cycles.
  - STI: 9 cycles.

Test Plan:
- Reset, memReady=1, ir=0x1042 (ADD) → INIT for 1 cycle. Then F0 shows ldPC=1, selPC=00, gatePC=1; F2 shows ldIR; ALU shows ldReg=ldCC=gateALU=1, aluK=00; F0 returns on cycle 6.
- ir=0x0A05 (BRnp) with n=0,z=1,p=0 → DEC goes straight to F0 with ldPC never 1 after fetch. Repeat with n=1 → BR state asserts selPC=01, selEAB2=10.
- ir=0xA203 (LDI) with memReady held low 3 cycles in each of F1, RDI and RD → each state stretches 3 cycles, ldMDR pulses only on the ready cycle, WB asserts ldCC.
- ir=0x4801 (JSR) → JSR0 asserts drMux=1, gatePC, ldReg; JSR1 asserts selEAB1=0, selEAB2=11. With ir=0x4080 (JSRR), JSR1 asserts selEAB1=1, selEAB2=00.
- MEM_TIMEOUT=4, memReady=0 forever → F1 held 4 cycles, then HALT with halted=1. Assert reset while in HALT → INIT on the next edge, halted=0.
- ir=0xF025 (TRAP) → HALT, halted=1 persists 20 cycles. Assert reset mid-ST1 → next state INIT, memWE drops to 0.
